// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
// State encoding is fixed so the datapath can decode it if needed.
package multdiv_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 6;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/multdiv_step_counter.sv
// Step index counter: sync clear beats enable.
// term flags the final step (count == WIDTH-1).
module multdiv_step_counter
  import multdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             term
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign term  = (count_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/multdiv_seq_ctrl.sv
// Sequencer for the iterative mult/div unit: INIT loads operands,
// RUN issues WIDTH steps, DONE reports result and div-by-zero.
module multdiv_seq_ctrl
  import multdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             ctrl_mult,
  input  logic             ctrl_div,
  input  logic             divisor_zero,
  output logic             load_en,
  output logic             acc_clr,
  output logic             step_en,
  output logic             step_last,
  output logic             op_div,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             data_ready,
  output logic             data_exception
);

  state_e state_q, state_d;
  logic   op_div_q, op_div_d;
  logic   exc_q, exc_d;
  logic   req;
  logic   cnt_clr;
  logic   cnt_en;
  logic   term;

  assign req = ctrl_mult | ctrl_div;

  multdiv_step_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .clr_n (clr_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (count),
    .term  (term)
  );

  // A request in any state restarts the sequence; mult wins a tie.
  always_comb begin
    state_d  = state_q;
    op_div_d = op_div_q;
    exc_d    = 1'b0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    if (req) begin
      state_d  = S_INIT;
      op_div_d = (ctrl_div & ~ctrl_mult) ? OP_DIV : OP_MULT;
      cnt_clr  = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_INIT: begin
          if ((op_div_q == OP_DIV) && divisor_zero) begin
            state_d = S_DONE;
            exc_d   = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (term) begin
            state_d = S_DONE;
            cnt_clr = 1'b1;
          end else begin
            cnt_en = 1'b1;
          end
        end
        S_DONE: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q  <= S_IDLE;
      op_div_q <= OP_MULT;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_div_q <= op_div_d;
      exc_q    <= exc_d;
    end
  end

  assign load_en        = (state_q == S_INIT);
  assign acc_clr        = (state_q == S_INIT);
  assign step_en        = (state_q == S_RUN);
  assign step_last      = step_en & term;
  assign op_div         = op_div_q;
  assign busy           = (state_q != S_IDLE);
  assign data_ready     = (state_q == S_DONE);
  assign data_exception = (state_q == S_DONE) & exc_q;

endmodule

// File: tb/tb_multdiv_seq_ctrl.sv
// Scoreboard bench for multdiv_seq_ctrl: stimulus queues expected
// completions, a negedge monitor checks each data_ready against them.
module tb_multdiv_seq_ctrl;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       ctrl_mult;
  logic       ctrl_div;
  logic       divisor_zero;
  logic       load_en;
  logic       acc_clr;
  logic       step_en;
  logic       step_last;
  logic       op_div;
  logic [5:0] count;
  logic       busy;
  logic       data_ready;
  logic       data_exception;

  typedef struct {
    int   cyc;
    logic op;
    logic exc;
    int   steps;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   cyc = 0;
  int   steps = 0;
  int   tests = 0;
  int   fails = 0;

  multdiv_seq_ctrl dut (
    .clk            (clk),
    .clr_n          (clr_n),
    .ctrl_mult      (ctrl_mult),
    .ctrl_div       (ctrl_div),
    .divisor_zero   (divisor_zero),
    .load_en        (load_en),
    .acc_clr        (acc_clr),
    .step_en        (step_en),
    .step_last      (step_last),
    .op_div         (op_div),
    .count          (count),
    .busy           (busy),
    .data_ready     (data_ready),
    .data_exception (data_exception)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int c, input logic op, input logic exc,
                      input int st);
    exp_t x;
    x.cyc   = c;
    x.op    = op;
    x.exc   = exc;
    x.steps = st;
    sbq.push_back(x);
  endtask

  // Monitor: pops one expectation per data_ready.
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (load_en === 1'b1) steps = 0;
      else if (step_en === 1'b1) steps++;
      if (data_ready === 1'b1) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_ready cyc=%0d got=1 want=0", cyc);
        end else begin
          e = sbq.pop_front();
          chk("ready_cyc", cyc, e.cyc);
          chk("ready_op", {31'd0, op_div}, {31'd0, e.op});
          chk("ready_exc", {31'd0, data_exception}, {31'd0, e.exc});
          chk("ready_steps", steps, e.steps);
        end
      end else begin
        chk("exc_without_ready", {31'd0, data_exception}, 32'd0);
      end
      if (step_last === 1'b1) begin
        chk("last_count", {26'd0, count}, 32'd31);
        chk("last_step_en", {31'd0, step_en}, 32'd1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    clr_n        = 1'b0;
    ctrl_mult    = 1'b1;
    ctrl_div     = 1'b0;
    divisor_zero = 1'b0;

    // Reset held with a pending request.
    for (int i = 1; i <= 3; i++) begin
      goto(i);
      @(negedge clk);
      chk("reset_outs",
          {18'd0, load_en, acc_clr, step_en, step_last, op_div,
           count, busy, data_ready, data_exception}, 32'd0);
    end
    clr_n     = 1'b1;
    ctrl_mult = 1'b0;

    // Plain multiply, request in cycle 5.
    goto(5);
    ctrl_mult = 1'b1;
    push(39, 1'b0, 1'b0, 32);
    goto(6);
    ctrl_mult = 1'b0;
    @(negedge clk);
    chk("init_load", {30'd0, load_en, acc_clr}, 32'd3);
    chk("init_step", {31'd0, step_en}, 32'd0);
    chk("init_busy", {31'd0, busy}, 32'd1);
    goto(7);
    @(negedge clk);
    chk("run0_step", {31'd0, step_en}, 32'd1);
    chk("run0_load", {30'd0, load_en, acc_clr}, 32'd0);
    chk("run0_count", {26'd0, count}, 32'd0);
    goto(37);
    @(negedge clk);
    chk("run30_count", {26'd0, count}, 32'd30);
    chk("run30_last", {31'd0, step_last}, 32'd0);
    goto(38);
    @(negedge clk);
    chk("run31_last", {31'd0, step_last}, 32'd1);
    goto(39);
    @(negedge clk);
    chk("done_count", {26'd0, count}, 32'd0);
    chk("done_step", {31'd0, step_en}, 32'd0);
    goto(40);
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Divide by zero: DONE two cycles after the request.
    goto(45);
    ctrl_div = 1'b1;
    push(47, 1'b1, 1'b1, 0);
    goto(46);
    ctrl_div     = 1'b0;
    divisor_zero = 1'b1;
    @(negedge clk);
    chk("dz_init_op", {31'd0, op_div}, 32'd1);
    goto(47);
    divisor_zero = 1'b0;
    @(negedge clk);
    chk("dz_no_step", {31'd0, step_en}, 32'd0);
    goto(48);
    @(negedge clk);
    chk("dz_idle", {31'd0, busy}, 32'd0);

    // Multiply ignores divisor_zero.
    goto(50);
    ctrl_mult    = 1'b1;
    divisor_zero = 1'b1;
    push(84, 1'b0, 1'b0, 32);
    goto(51);
    ctrl_mult = 1'b0;
    goto(85);
    divisor_zero = 1'b0;

    // Normal divide.
    goto(90);
    ctrl_div = 1'b1;
    push(124, 1'b1, 1'b0, 32);
    goto(91);
    ctrl_div = 1'b0;

    // Divide aborted by a multiply at count 10.
    goto(130);
    ctrl_div = 1'b1;
    goto(131);
    ctrl_div = 1'b0;
    goto(142);
    ctrl_mult = 1'b1;
    push(176, 1'b0, 1'b0, 32);
    @(negedge clk);
    chk("abort_at10", {26'd0, count}, 32'd10);
    goto(143);
    ctrl_mult = 1'b0;
    @(negedge clk);
    chk("abort_init", {31'd0, load_en}, 32'd1);
    chk("abort_op", {31'd0, op_div}, 32'd0);
    chk("abort_count", {26'd0, count}, 32'd0);

    // Tie goes to multiply; request in DONE chains directly.
    goto(180);
    ctrl_mult = 1'b1;
    ctrl_div  = 1'b1;
    push(214, 1'b0, 1'b0, 32);
    goto(181);
    ctrl_mult = 1'b0;
    ctrl_div  = 1'b0;
    @(negedge clk);
    chk("tie_op", {31'd0, op_div}, 32'd0);
    goto(214);
    ctrl_div = 1'b1;
    push(248, 1'b1, 1'b0, 32);
    goto(215);
    ctrl_div = 1'b0;
    @(negedge clk);
    chk("b2b_init", {30'd0, load_en, busy}, 32'd3);
    chk("b2b_op", {31'd0, op_div}, 32'd1);

    // Reset in the middle of RUN.
    goto(252);
    ctrl_mult = 1'b1;
    goto(253);
    ctrl_mult = 1'b0;
    goto(274);
    @(negedge clk);
    chk("rst_at20", {26'd0, count}, 32'd20);
    clr_n = 1'b0;
    goto(275);
    @(negedge clk);
    chk("rst_run_outs",
        {26'd0, busy, step_en, count[3:0]}, 32'd0);
    clr_n = 1'b1;

    goto(300);
    ctrl_div = 1'b1;
    push(334, 1'b1, 1'b0, 32);
    goto(301);
    ctrl_div = 1'b0;

    goto(340);
    @(negedge clk);
    chk("sb_empty", sbq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
